key_unlock_ctrl: RTL and testbench

KEY_UNLOCK_CTRL -- requirements
Module: key_unlock_ctrl

---
 rtl/key_unlock_pkg.sv | 9 +
 rtl/key_unlock_ctrl_rr_arb.sv | 37 +++
 rtl/key_unlock_ctrl.sv | 107 ++++++++++
 tb/tb_key_unlock_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_unlock_pkg.sv
// key_unlock_pkg: state encoding and key-match rule shared by key_unlock_ctrl and its bench-facing logic
package key_unlock_pkg;
    typedef enum logic [2:0] {WAKE, IDLE, CHECK, UNLOCKED, LOCKOUT} state_t;
    localparam logic [7:0] KEY_MASK  = 8'hA5;
    localparam logic [7:0] KEY_VALUE = 8'h84;
    function automatic logic key_match(input logic [7:0] k);
        return (k & KEY_MASK) == KEY_VALUE;
    endfunction
endpackage

// File: rtl/key_unlock_ctrl_rr_arb.sv
// rr_arb: round-robin arbiter
//   clk, rstn : clock, synchronous active-low reset (priority back to requester 0)
//   req       : request vector
//   adv       : advance strobe; moves priority past the current winner
//   gnt       : combinational one-hot winner (zero when no request)
module rr_arb #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] req,
    input  logic         adv,
    output logic [N-1:0] gnt
);
    localparam int PW = $clog2(N);
    logic [PW-1:0] ptr, idx, gidx;
    // Scan from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        gnt  = '0;
        gidx = '0;
        idx  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % N);
            if (req[idx]) begin
                gnt       = '0;
                gnt[idx]  = 1'b1;
                gidx      = idx;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rstn)
            ptr <= '0;
        else if (adv)
            ptr <= (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
    end
endmodule

// File: rtl/key_unlock_ctrl.sv
// key_unlock_ctrl: arbitrated key check with failure lockout
//   clk, rstn  : clock, synchronous active-low reset
//   req, key   : per-requester level request and 8-bit key (requester i at key[8*i+7:8*i])
//   relock     : only with KEY_UNLOCK_CTRL_RELOCK_EN; returns UNLOCKED to IDLE
//   gnt        : one-hot grant pulse
//   done, pass : one-cycle result strobe and result
//   unlocked, locked_out, fail_cnt : status levels
module key_unlock_ctrl
    import key_unlock_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*8-1:0] key,
`ifdef KEY_UNLOCK_CTRL_RELOCK_EN
    input  logic              relock,
`endif
    output logic [NREQ-1:0]   gnt,
    output logic              done,
    output logic              pass,
    output logic              unlocked,
    output logic              locked_out,
    output logic [3:0]        fail_cnt
);
    state_t state, nstate;
    logic [1:0] wake_sr;
    logic [7:0] timer, key_q, sel_key;
    logic [NREQ-1:0] arb_gnt, gnt_d;
    logic [3:0] fail_inc, fail_d;
    logic adv, match, relock_i, done_d, pass_d, unl_d, lo_d;
`ifdef KEY_UNLOCK_CTRL_RELOCK_EN
    assign relock_i = relock;
`else
    assign relock_i = 1'b0;
`endif
    assign adv      = (state == IDLE) && |req;
    assign match    = key_match(key_q);
    assign fail_inc = (fail_cnt == 4'(MAX_FAIL)) ? fail_cnt : fail_cnt + 4'd1;
    rr_arb #(.N(NREQ)) u_arb (
        .clk  (clk),
        .rstn (rstn),
        .req  (req),
        .adv  (adv),
        .gnt  (arb_gnt)
    );
    always_comb begin
        sel_key = '0;
        for (int i = 0; i < NREQ; i++)
            sel_key = sel_key | (key[8*i +: 8] & {8{arb_gnt[i]}});
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= WAKE;
            wake_sr <= '0;
            timer   <= '0;
            key_q   <= '0;
        end else begin
            state   <= nstate;
            wake_sr <= {wake_sr[0], 1'b1};
            timer   <= (state == CHECK) ? 8'(LOCK_CYCLES - 1) :
                       (state == LOCKOUT && timer != 8'd0) ? timer - 8'd1 : timer;
            key_q   <= adv ? sel_key : key_q;
        end
    end
    // WAKE leaves on the edge that fills the second shift-register stage.
    always_comb begin
        nstate = state;
        case (state)
            WAKE:     nstate = (wake_sr == 2'b01) ? IDLE : WAKE;
            IDLE:     nstate = |req ? CHECK : IDLE;
            CHECK:    nstate = match ? UNLOCKED : (fail_inc == 4'(MAX_FAIL)) ? LOCKOUT : IDLE;
            UNLOCKED: nstate = relock_i ? IDLE : UNLOCKED;
            LOCKOUT:  nstate = (timer == 8'd0) ? IDLE : LOCKOUT;
            default:  nstate = WAKE;
        endcase
    end
    always_comb begin
        gnt_d  = (state == IDLE) ? arb_gnt : '0;
        done_d = state == CHECK;
        pass_d = done_d && match;
        unl_d  = nstate == UNLOCKED;
        lo_d   = nstate == LOCKOUT;
        fail_d = (state == CHECK) ? (match ? 4'd0 : fail_inc) :
                 ((state inside {LOCKOUT, UNLOCKED}) && nstate == IDLE) ? 4'd0 : fail_cnt;
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            gnt        <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            unlocked   <= 1'b0;
            locked_out <= 1'b0;
            fail_cnt   <= '0;
        end else begin
            gnt        <= gnt_d;
            done       <= done_d;
            pass       <= pass_d;
            unlocked   <= unl_d;
            locked_out <= lo_d;
            fail_cnt   <= fail_d;
        end
    end
endmodule

// File: tb/tb_key_unlock_ctrl.sv
// tb_key_unlock_ctrl: directed bench with a cycle-level behavioural reference for key_unlock_ctrl
module tb_key_unlock_ctrl;
    localparam int NREQ = 4;
    localparam int MAX_FAIL = 3;
    localparam int LOCK = 16;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [3:0] req = '0;
    logic [31:0] key = '0;
    logic relock = 1'b0;
    logic [3:0] gnt;
    logic done, pass, unlocked, locked_out;
    logic [3:0] fail_cnt;
    int tests = 0;
    int fails = 0;
    always #5 clk = ~clk;
    key_unlock_ctrl #(.NREQ(NREQ), .MAX_FAIL(MAX_FAIL), .LOCK_CYCLES(LOCK)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req        (req),
        .key        (key),
`ifdef KEY_UNLOCK_CTRL_RELOCK_EN
        .relock     (relock),
`endif
        .gnt        (gnt),
        .done       (done),
        .pass       (pass),
        .unlocked   (unlocked),
        .locked_out (locked_out),
        .fail_cnt   (fail_cnt)
    );
    // Reference: counts of wake edges, pending check, remaining lockout cycles.
    int m_wake = 0, m_lock = 0, m_prio = 0, m_fc = 0;
    bit m_chk = 0, m_unl = 0, armed = 0, m_done = 0, m_pass = 0;
    logic [7:0] m_key = '0;
    logic [3:0] m_gnt = '0;
    task automatic step();
        int gi;
        armed = 1;
        if (!rstn) begin
            m_wake = 0; m_lock = 0; m_prio = 0; m_fc = 0;
            m_chk = 0; m_unl = 0; m_gnt = '0; m_done = 0; m_pass = 0;
        end else begin
            m_gnt = '0; m_done = 0; m_pass = 0;
            if (m_chk) begin
                m_chk = 0;
                m_done = 1;
                m_pass = ((m_key & 8'hA5) == 8'h84);
                if (m_pass) begin
                    m_unl = 1; m_fc = 0;
                end else begin
                    m_fc = (m_fc < MAX_FAIL) ? m_fc + 1 : m_fc;
                    if (m_fc == MAX_FAIL) m_lock = LOCK;
                end
            end else if (m_wake < 2) begin
                m_wake++;
            end else if (m_lock > 0) begin
                m_lock--;
                if (m_lock == 0) m_fc = 0;
            end else if (m_unl) begin
                if (relock) begin m_unl = 0; m_fc = 0; end
            end else begin
                gi = -1;
                for (int k = 0; k < NREQ; k++)
                    if (gi < 0 && req[(m_prio + k) % NREQ]) gi = (m_prio + k) % NREQ;
                if (gi >= 0) begin
                    m_gnt[gi] = 1'b1;
                    m_key = key[8*gi +: 8];
                    m_chk = 1;
                    m_prio = (gi + 1) % NREQ;
                end
            end
        end
    endtask
    initial forever begin
        @(posedge clk);
        step();
    end
    initial forever begin
        @(negedge clk);
        if (armed) begin
            tests++;
            if ({gnt, done, pass, unlocked, locked_out, fail_cnt} !==
                {m_gnt, m_done, m_pass, m_unl, (m_lock > 0), 4'(m_fc)}) begin
                fails++;
                $display("FAIL model_cmp t=%0t: got gnt=%b done=%b pass=%b unl=%b lo=%b fc=%0d, expected gnt=%b done=%b pass=%b unl=%b lo=%b fc=%0d",
                    $time, gnt, done, pass, unlocked, locked_out, fail_cnt,
                    m_gnt, m_done, m_pass, m_unl, (m_lock > 0), m_fc);
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask
    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
    endtask
    task automatic release_wake();
        rstn = 1'b1;
        @(negedge clk);
        chk("wake_c1_gnt", 32'(gnt), 0);
        @(negedge clk);
        chk("wake_c2_gnt", 32'(gnt), 0);
    endtask
    task automatic attempt(input int i, input logic [7:0] k, input logic [7:0] alt,
                           output logic p, output logic [3:0] f);
        int n;
        n = 0;
        key[8*i +: 8] = k;
        req = '0;
        req[i] = 1'b1;
        while (gnt == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("attempt_gnt", 32'(gnt), 32'(1 << i));
        req = '0;
        key[8*i +: 8] = alt;
        @(negedge clk);
        chk("attempt_done", 32'(done), 1);
        p = pass;
        f = fail_cnt;
        @(negedge clk);
    endtask
    logic [3:0] gq [4];
    logic [3:0] fq [3];
    logic p;
    logic [3:0] f;
    int g, d, lo_n, n;
    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({gnt, done, pass, unlocked, locked_out, fail_cnt}), 0);
        // Wake timing and a passing key from requester 0
        req = 4'b0001;
        key[7:0] = 8'h84;
        release_wake();
        @(negedge clk);
        chk("first_idle_gnt", 32'(gnt), 32'h1);
        req = '0;
        key[7:0] = 8'h00;
        @(negedge clk);
        chk("t1_done", 32'(done), 1);
        chk("t1_pass", 32'(pass), 1);
        chk("t1_unlocked", 32'(unlocked), 1);
        chk("t1_fail_cnt", 32'(fail_cnt), 0);
        req = 4'b0010;
        repeat (5) begin
            @(negedge clk);
            chk("unlocked_no_gnt", 32'(gnt), 0);
        end
        chk("unlocked_sticky", 32'(unlocked), 1);
        req = '0;
        // Three failures, lockout, round-robin continues at requester 3
        do_reset();
        req = 4'hF;
        key = '0;
        rstn = 1'b1;
        g = 0; d = 0; lo_n = 0; n = 0;
        foreach (gq[i]) gq[i] = '0;
        foreach (fq[i]) fq[i] = '0;
        while (g < 4 && n < 80) begin
            @(negedge clk);
            n++;
            if (locked_out) lo_n++;
            if (done && d < 3) begin fq[d] = fail_cnt; d++; end
            if (gnt != '0) begin gq[g] = gnt; g++; end
        end
        req = '0;
        chk("t2_grants_seen", 32'(g), 4);
        chk("t2_gnt0", 32'(gq[0]), 32'h1);
        chk("t2_gnt1", 32'(gq[1]), 32'h2);
        chk("t2_gnt2", 32'(gq[2]), 32'h4);
        chk("t2_gnt3", 32'(gq[3]), 32'h8);
        chk("t2_fc1", 32'(fq[0]), 1);
        chk("t2_fc2", 32'(fq[1]), 2);
        chk("t2_fc3", 32'(fq[2]), 3);
        chk("t2_lock_cycles", 32'(lo_n), 16);
        chk("t2_fc_cleared", 32'(fail_cnt), 0);
        repeat (2) @(negedge clk);
        // Two failures then a don't-care-bit match; key changes after grant ignored
        do_reset();
        rstn = 1'b1;
        attempt(0, 8'hFF, 8'h84, p, f);
        chk("t3_a1_pass", 32'(p), 0);
        chk("t3_a1_fc", 32'(f), 1);
        attempt(0, 8'hFF, 8'h84, p, f);
        chk("t3_a2_pass", 32'(p), 0);
        chk("t3_a2_fc", 32'(f), 2);
        attempt(0, 8'h86, 8'h00, p, f);
        chk("t3_a3_pass", 32'(p), 1);
        chk("t3_a3_fc", 32'(f), 0);
        chk("t3_unlocked", 32'(unlocked), 1);
`ifdef KEY_UNLOCK_CTRL_RELOCK_EN
        req = 4'b0010;
        key[15:8] = 8'h84;
        @(negedge clk);
        relock = 1'b1;
        @(negedge clk);
        relock = 1'b0;
        chk("relock_unlocked", 32'(unlocked), 0);
        chk("relock_no_gnt", 32'(gnt), 0);
        @(negedge clk);
        chk("relock_next_gnt", 32'(gnt), 32'h2);
        req = '0;
        repeat (2) @(negedge clk);
`endif
        // Reset during CHECK suppresses done and re-enters WAKE
        do_reset();
        req = 4'b0001;
        key[7:0] = 8'h84;
        release_wake();
        @(negedge clk);
        chk("t4_gnt", 32'(gnt), 32'h1);
        rstn = 1'b0;
        @(negedge clk);
        chk("t4_rst_in_check", 32'({gnt, done, pass, unlocked, locked_out, fail_cnt}), 0);
        release_wake();
        chk("t4_no_done", 32'(done), 0);
        @(negedge clk);
        chk("t4_regnt", 32'(gnt), 32'h1);
        req = '0;
        @(negedge clk);
        chk("t4_done", 32'(done), 1);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
